// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the streaming FIFO: pointer width, a constant-foldable
// ceiling log2, and the default almost-full / almost-empty thresholds.
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int DEFAULT_ADDR_LENGTH = 4;
   localparam int DEFAULT_PTR_WIDTH   = DEFAULT_ADDR_LENGTH + 1;

   // Ceiling log2, usable in constant expressions.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

   // Pointers carry one extra wrap bit above the address.
   function automatic int ptr_width(input int addr_length);
      return addr_length + 1;
   endfunction

   // Almost-full by default one word before full.
   function automatic int default_almost_full_level(input int addr_length);
      return (1 << addr_length) - 1;
   endfunction

   // Almost-empty by default with at most one word left.
   function automatic int default_almost_empty_level();
      return 1;
   endfunction

endpackage

// File: rtl/fifo_stream_mem.sv
// -----------------------------------------------------------------------------
// fifo_stream_mem
// Dual-port storage array: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
//   i_clk      write clock
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_addr  read address
//   o_rd_data  read data (combinational)
// -----------------------------------------------------------------------------
module fifo_stream_mem #(
   parameter int ADDR_LENGTH = 4,
   parameter int WORD_LENGTH = 8
) (
   input  logic                   i_clk,
   input  logic                   i_wr_en,
   input  logic [ADDR_LENGTH-1:0] i_wr_addr,
   input  logic [WORD_LENGTH-1:0] i_wr_data,
   input  logic [ADDR_LENGTH-1:0] i_rd_addr,
   output logic [WORD_LENGTH-1:0] o_rd_data
);

   localparam int DEPTH = 1 << ADDR_LENGTH;

   logic [WORD_LENGTH-1:0] mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/fifo_stream.sv
// -----------------------------------------------------------------------------
// fifo_stream
// First-word-fall-through FIFO with valid/ready on both sides, occupancy
// count, programmable almost-full/almost-empty flags and synchronous flush.
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_flush                 synchronous clear, overrides push and pop
//   i_data_in, i_data_in_valid, o_ready_in       write side
//   o_data_out, o_data_out_valid, i_ready_out    read side (FWFT head word)
//   o_count                 words stored, 0..DEPTH
//   o_full, o_empty, o_almost_full, o_almost_empty   registered status flags
// -----------------------------------------------------------------------------
module fifo_stream
   import fifo_pkg::*;
#(
   parameter int ADDR_LENGTH        = DEFAULT_ADDR_LENGTH,
   parameter int WORD_LENGTH        = 8,
   parameter int ALMOST_FULL_LEVEL  = default_almost_full_level(ADDR_LENGTH),
   parameter int ALMOST_EMPTY_LEVEL = default_almost_empty_level()
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic                   i_flush,
   input  logic [WORD_LENGTH-1:0] i_data_in,
   input  logic                   i_data_in_valid,
   output logic                   o_ready_in,
   output logic [WORD_LENGTH-1:0] o_data_out,
   output logic                   o_data_out_valid,
   input  logic                   i_ready_out,
   output logic [ADDR_LENGTH:0]   o_count,
   output logic                   o_full,
   output logic                   o_empty,
   output logic                   o_almost_full,
   output logic                   o_almost_empty
);

   localparam int PTR_W = ptr_width(ADDR_LENGTH);
   localparam int DEPTH = 1 << ADDR_LENGTH;
   localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] AF_C    = PTR_W'(ALMOST_FULL_LEVEL);
   localparam logic [PTR_W-1:0] AE_C    = PTR_W'(ALMOST_EMPTY_LEVEL);
   localparam logic [PTR_W-1:0] ONE_C   = PTR_W'(1);

   if (ADDR_LENGTH < 1 || ADDR_LENGTH > 12 || clog2(DEPTH) != ADDR_LENGTH) begin : g_bad_addr
      $error("fifo_stream: ADDR_LENGTH must be in 1..12");
   end
   if (WORD_LENGTH < 1) begin : g_bad_word
      $error("fifo_stream: WORD_LENGTH must be >= 1");
   end
   if (ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_af
      $error("fifo_stream: ALMOST_FULL_LEVEL must be in 1..DEPTH");
   end
   if (ALMOST_EMPTY_LEVEL < 0 || ALMOST_EMPTY_LEVEL > DEPTH - 1) begin : g_bad_ae
      $error("fifo_stream: ALMOST_EMPTY_LEVEL must be in 0..DEPTH-1");
   end

   logic [PTR_W-1:0]       wptr;
   logic [PTR_W-1:0]       rptr;
   logic [PTR_W-1:0]       count;
   logic [PTR_W-1:0]       count_nxt;
   logic                   full_q;
   logic                   empty_q;
   logic                   almost_full_q;
   logic                   almost_empty_q;
   logic                   push;
   logic                   pop;
   logic [WORD_LENGTH-1:0] rd_data;

   // Flush masks both handshakes, so a flush cycle never moves data.
   assign o_ready_in       = !full_q  && !i_flush;
   assign o_data_out_valid = !empty_q && !i_flush;
   assign push             = i_data_in_valid && o_ready_in;
   assign pop              = o_data_out_valid && i_ready_out;

   always_comb begin
      count_nxt = count;
      if (i_flush) begin
         count_nxt = '0;
      end else if (push && !pop) begin
         count_nxt = count + ONE_C;
      end else if (pop && !push) begin
         count_nxt = count - ONE_C;
      end
   end

   // Flags are registered from the next count so they change cleanly at the
   // edge instead of rippling through a comparator after it.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wptr           <= '0;
         rptr           <= '0;
         count          <= '0;
         full_q         <= 1'b0;
         empty_q        <= 1'b1;
         almost_full_q  <= 1'b0;
         almost_empty_q <= 1'b1;
      end else begin
         if (i_flush) begin
            wptr <= '0;
            rptr <= '0;
         end else begin
            if (push) wptr <= wptr + ONE_C;
            if (pop)  rptr <= rptr + ONE_C;
         end
         count          <= count_nxt;
         full_q         <= (count_nxt == DEPTH_C);
         empty_q        <= (count_nxt == '0);
         almost_full_q  <= (count_nxt >= AF_C);
         almost_empty_q <= (count_nxt <= AE_C);
      end
   end

   fifo_stream_mem #(
      .ADDR_LENGTH (ADDR_LENGTH),
      .WORD_LENGTH (WORD_LENGTH)
   ) u_mem (
      .i_clk     (i_clk),
      .i_wr_en   (push),
      .i_wr_addr (wptr[ADDR_LENGTH-1:0]),
      .i_wr_data (i_data_in),
      .i_rd_addr (rptr[ADDR_LENGTH-1:0]),
      .o_rd_data (rd_data)
   );

   // Stale array contents never leak out while empty.
   assign o_data_out     = empty_q ? '0 : rd_data;
   assign o_count        = count;
   assign o_full         = full_q;
   assign o_empty        = empty_q;
   assign o_almost_full  = almost_full_q;
   assign o_almost_empty = almost_empty_q;

`ifndef SYNTHESIS
   // Count must never exceed DEPTH and must track the pointer distance.
   a_count_range : assert property (@(posedge i_clk) disable iff (!i_reset_n)
      (count <= DEPTH_C) && (count == PTR_W'(wptr - rptr)));
`endif

endmodule

// File: tb/tb_fifo_stream.sv
module tb_fifo_stream;

   localparam int DEPTH = 16;
   localparam int AF    = DEPTH - 1;
   localparam int AE    = 1;

   logic       clk;
   logic       i_reset_n;
   logic       i_flush;
   logic [7:0] i_data_in;
   logic       i_data_in_valid;
   logic       o_ready_in;
   logic [7:0] o_data_out;
   logic       o_data_out_valid;
   logic       i_ready_out;
   logic [4:0] o_count;
   logic       o_full;
   logic       o_empty;
   logic       o_almost_full;
   logic       o_almost_empty;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: the stored words in order, head at index 0.
   logic [7:0] q[$];

   logic [18:0] pre_obs;
   logic [18:0] pre_exp;

   fifo_stream dut (
      .i_clk            (clk),
      .i_reset_n        (i_reset_n),
      .i_flush          (i_flush),
      .i_data_in        (i_data_in),
      .i_data_in_valid  (i_data_in_valid),
      .o_ready_in       (o_ready_in),
      .o_data_out       (o_data_out),
      .o_data_out_valid (o_data_out_valid),
      .i_ready_out      (i_ready_out),
      .o_count          (o_count),
      .o_full           (o_full),
      .o_empty          (o_empty),
      .o_almost_full    (o_almost_full),
      .o_almost_empty   (o_almost_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {count, full, empty, afull, aempty, valid, ready, data}
   function automatic logic [18:0] obs_vec();
      return {o_count, o_full, o_empty, o_almost_full, o_almost_empty,
              o_data_out_valid, o_ready_in, o_data_out};
   endfunction

   function automatic logic [18:0] exp_vec();
      int n;
      logic [7:0] d;
      n = q.size();
      d = (n > 0) ? q[0] : 8'h00;
      return {5'(n), (n == DEPTH), (n == 0), (n >= AF), (n <= AE),
              ((n > 0) && !i_flush), ((n < DEPTH) && !i_flush), d};
   endfunction

   // Drive one cycle, capture pre-edge outputs, advance the model at the edge.
   task automatic step(input logic v, input logic [7:0] d, input logic r, input logic f);
      int n;
      logic do_push, do_pop;
      i_data_in_valid = v;
      i_data_in       = d;
      i_ready_out     = r;
      i_flush         = f;
      #1;
      pre_obs = obs_vec();
      pre_exp = exp_vec();
      n = q.size();
      do_push = v && (n < DEPTH) && !f;
      do_pop  = r && (n > 0) && !f;
      @(posedge clk);
      if (f) begin
         q.delete();
      end else begin
         if (do_pop)  void'(q.pop_front());
         if (do_push) q.push_back(d);
      end
      #1;
   endtask

   task automatic test_reset();
      i_reset_n = 1'b0;
      i_flush = 1'b0; i_data_in = 8'h00; i_data_in_valid = 1'b0; i_ready_out = 1'b0;
      q.delete();
      repeat (2) @(posedge clk);
      #1 i_reset_n = 1'b1;
      #1;
      n_checks++;
      if (obs_vec() !== 19'b00000_0_1_0_1_0_1_00000000)
         $display("FAIL reset_state: got %h expected %h", obs_vec(), 19'b00000_0_1_0_1_0_1_00000000);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_fill();
      for (int i = 1; i <= DEPTH; i++) begin
         step(1'b1, 8'(i), 1'b0, 1'b0);
         n_checks++;
         if (pre_obs !== pre_exp) $display("FAIL fill_pre[%0d]: got %h expected %h", i, pre_obs, pre_exp);
         else n_pass++;
         n_checks++;
         if (obs_vec() !== exp_vec() || o_count !== 5'(i))
            $display("FAIL fill_post[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
         else n_pass++;
      end
      step(1'b1, 8'h11, 1'b0, 1'b0);
      n_checks++;
      if (pre_obs[8] !== 1'b0 || o_count !== 5'd16 || o_full !== 1'b1 || o_data_out !== 8'h01)
         $display("FAIL fill_overflow: got ready=%b count=%0d data=%h required ready=0 count=16 data=01",
                  pre_obs[8], o_count, o_data_out);
      else n_pass++;
   endtask

   task automatic test_stream();
      logic [7:0] next_in, next_out;
      next_in = 8'h11;
      next_out = 8'h01;
      for (int k = 0; k < 40; k++) begin
         step(1'b1, next_in, 1'b1, 1'b0);
         if (pre_obs[8]) next_in++;
         n_checks++;
         if (pre_obs !== pre_exp || pre_obs[7:0] !== next_out)
            $display("FAIL stream_pre[%0d]: got %h expected %h head %h", k, pre_obs, pre_exp, next_out);
         else n_pass++;
         next_out++;
         n_checks++;
         if (obs_vec() !== exp_vec() || o_count !== 5'd15)
            $display("FAIL stream_post[%0d]: got %h expected %h", k, obs_vec(), exp_vec());
         else n_pass++;
      end
   endtask

   task automatic test_single();
      for (int k = 0; k < 2 * DEPTH && q.size() > 0; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (o_empty !== 1'b1) $display("FAIL single_drain: got empty=%b required 1", o_empty);
      else n_pass++;
      step(1'b1, 8'hA5, 1'b1, 1'b0);
      n_checks++;
      if (pre_obs[9] !== 1'b0 || o_data_out_valid !== 1'b1 || o_data_out !== 8'hA5)
         $display("FAIL single_latency: got pre_valid=%b valid=%b data=%h required 0 1 a5",
                  pre_obs[9], o_data_out_valid, o_data_out);
      else n_pass++;
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec() || o_empty !== 1'b1 || o_count !== 5'd0)
         $display("FAIL single_pop: got %h expected %h", obs_vec(), exp_vec());
      else n_pass++;
   endtask

   task automatic test_flush();
      for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
      n_checks++;
      if (o_count !== 5'd7) $display("FAIL flush_fill: got count=%0d required 7", o_count);
      else n_pass++;
      step(1'b1, 8'hEE, 1'b1, 1'b1);
      n_checks++;
      if (pre_obs[9:8] !== 2'b00) $display("FAIL flush_mask: got valid,ready=%b required 00", pre_obs[9:8]);
      else n_pass++;
      step(1'b0, 8'h00, 1'b0, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec() || o_count !== 5'd0 || o_empty !== 1'b1)
         $display("FAIL flush_clear: got %h expected %h", obs_vec(), exp_vec());
      else n_pass++;
      step(1'b1, 8'h3C, 1'b0, 1'b0);
      n_checks++;
      if (o_count !== 5'd1 || o_data_out !== 8'h3C)
         $display("FAIL flush_after: got count=%0d data=%h required 1 3c", o_count, o_data_out);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
      n_checks++;
      if (o_count !== 5'd9) $display("FAIL areset_fill: got count=%0d required 9", o_count);
      else n_pass++;
      i_data_in_valid = 1'b0; i_ready_out = 1'b0;
      #2 i_reset_n = 1'b0;
      q.delete();
      #1;
      n_checks++;
      if (obs_vec() !== exp_vec() || o_count !== 5'd0 || o_data_out !== 8'h00)
         $display("FAIL areset_async: got %h expected %h", obs_vec(), exp_vec());
      else n_pass++;
      @(posedge clk);
      #1 i_reset_n = 1'b1;
      step(1'b1, 8'h77, 1'b0, 1'b0);
      step(1'b1, 8'h78, 1'b0, 1'b0);
      n_checks++;
      if (o_data_out !== 8'h77 || o_count !== 5'd2)
         $display("FAIL areset_first: got data=%h count=%0d required 77 2", o_data_out, o_count);
      else n_pass++;
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (o_data_out !== 8'h78) $display("FAIL areset_second: got %h required 78", o_data_out);
      else n_pass++;
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int k = 0; k < 600; k++) begin
         logic v, r, f;
         // Alternate producer-heavy and consumer-heavy phases to sweep occupancy.
         if (((k / 75) % 2) == 0) begin
            v = ($urandom % 4) != 0;
            r = ($urandom % 4) == 0;
         end else begin
            v = ($urandom % 4) == 0;
            r = ($urandom % 4) != 0;
         end
         f = ($urandom % 50) == 0;
         step(v, 8'($urandom), r, f);
         n_checks++;
         if (pre_obs !== pre_exp) begin
            if (errs < 10) $display("FAIL random_pre[%0d]: got %h expected %h", k, pre_obs, pre_exp);
            errs++;
         end else n_pass++;
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            if (errs < 10) $display("FAIL random_post[%0d]: got %h expected %h", k, obs_vec(), exp_vec());
            errs++;
         end else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_stream();
      test_single();
      test_flush();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fifo_stream.md
Name: fifo_stream

Overview:
- Parametrised first-word-fall-through (FWFT) FIFO with standard valid/ready handshakes on both sides.
- Sustains one push and one pop per cycle, with no idle or wait states between transfers.
- Adds an occupancy count, programmable almost-full/almost-empty flags and a synchronous flush.
- Sits between streaming producers/consumers (UART, SPI, I2C cores) as the successor to the handshake FIFO wrapper.

Parameters:
- ADDR_LENGTH, 4: depth is DEPTH = 2^ADDR_LENGTH words; legal range 1..12.
- WORD_LENGTH, 8: data width in bits; must be >= 1.
- ALMOST_FULL_LEVEL, DEPTH-1: o_almost_full asserts when count >= this value; legal range 1..DEPTH.
- ALMOST_EMPTY_LEVEL, 1: o_almost_empty asserts when count <= this value; legal range 0..DEPTH-1.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_flush  in  1  synchronous clear of contents; has priority over push and pop.
- i_data_in  in  WORD_LENGTH  write data.
- i_data_in_valid  in  1  producer has data.
- o_ready_in  out  1  FIFO can accept a word.
- o_data_out  out  WORD_LENGTH  head word.
- o_data_out_valid  out  1  head word present.
- i_ready_out  in  1  consumer takes the head word.
- o_count  out  ADDR_LENGTH+1  words stored, 0..DEPTH.
- o_full  out  1  count == DEPTH.
- o_empty  out  1  count == 0.
- o_almost_full  out  1  count >= ALMOST_FULL_LEVEL.
- o_almost_empty  out  1  count <= ALMOST_EMPTY_LEVEL.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. Ports are i_clk and i_reset_n.
- Reset (i_reset_n=0, takes effect immediately, no clock needed):
  - write and read pointers = 0, count = 0.
  - o_empty=1, o_full=0, o_count=0, o_data_out_valid=0, o_data_out=0.
  - o_ready_in=1 once reset is released.
  - o_almost_empty=1; o_almost_full=0.
- Storage: a memory array that is not reset. Pointers are ADDR_LENGTH+1 bits wide; the extra MSB is the wrap bit.
  - full: the pointers differ only in the MSB.
  - empty: the pointers are equal.
  - Pointers wrap naturally modulo 2*DEPTH.
- Handshake:
  - push = i_data_in_valid & o_ready_in.
  - pop = o_data_out_valid & i_ready_out.
  - o_ready_in = !o_full & !i_flush.
  - o_data_out_valid = !o_empty & !i_flush.
  - No other combinational input-to-output paths exist.
- Push: i_data_in is written at mem[wptr]; wptr increments.
- Pop: rptr increments.
- o_data_out:
  - mem[rptr] read combinationally (FWFT); a word pushed at edge k appears on o_data_out with valid=1 after edge k (latency 1).
  - Forced to 0 while o_empty=1.
  - Holds stable while valid=1 and i_ready_out=0.
- Count update:
  - push & !pop: count+1.
  - pop & !push: count-1.
  - push & pop: unchanged, both pointers advance.
  - Count is held in a register, not derived from the pointers, and always equals wptr-rptr modulo 2*DEPTH.
- Boundaries:
  - Full: push is impossible (ready=0). A pop frees a slot, so o_ready_in=1 on the next cycle.
  - Empty: pop is impossible. A simultaneous push and i_ready_out=1 yields the word on the next cycle; there is no bypass.
  - Full and pop in the same cycle: no push, count goes to DEPTH-1.
- Flush: at the edge where i_flush=1:
  - Both pointers and count are set to 0; all flags return to their reset values.
  - The push or pop is suppressed because ready and valid are masked that cycle.
- Flags are decoded from registered count only. They must be glitch-free relative to the edge.
- Reset asserted mid-transfer: the transfer is aborted and contents are lost; outputs take their reset values asynchronously.
- Arithmetic: count saturation is not needed because the handshake masking prevents overflow and underflow. A simulation assertion flags count > DEPTH.

Decomposition:
- Package fifo_pkg holds:
  - function clog2;
  - localparams for pointer width (ADDR_LENGTH+1);
  - default threshold helpers.
- Sub-module fifo_stream_mem: dual-port array, synchronous write port, asynchronous read port, parameters ADDR_LENGTH and WORD_LENGTH.
- The top level holds the pointers, count, flags and handshake masking.

Test Plan:
- Reset then idle, DEPTH=16, WORD=8 -> o_empty=1, o_count=0, o_ready_in=1, o_data_out_valid=0, o_data_out=0, o_almost_empty=1.
- Push 0x01..0x10 with i_ready_out=0 -> o_count steps 1..16; o_almost_full first at count 15; o_full=1 and o_ready_in=0 after the 16th; a 17th valid is not accepted; o_data_out stays 0x01.
- From full, hold i_ready_out=1 and i_data_in_valid=1 with 0x11.. ->
  - the first cycle pops 0x01 only, count goes to 15;
  - afterwards push and pop each cycle, count stays 15, output order 0x01,0x02,...;
  - pointers wrap with no loss.
- From empty, pulse a single push of 0xA5 with i_ready_out=1 -> valid rises 1 cycle later with data 0xA5, popped that cycle; o_empty=1 again the next cycle.
- Fill to 7, then assert i_flush with a simultaneous valid push and ready pop -> next cycle count=0, o_empty=1, ready and valid were low during the flush cycle, and the pushed word is absent.
- Assert i_reset_n=0 between clock edges while at count 9 -> outputs go to reset values before the next edge; the first word pushed after release is the first word out.
